// File: rtl/oled_frame_streamer_if.sv
// Framebuffer read port and display byte stream of the OLED frame streamer, bundled for one port connection.
// The master modport is the streamer side. The slave modport is the framebuffer/serializer side.
interface oled_frame_streamer_if;
  logic       fb_rst_complete;
  logic       fb_re;
  logic       fb_r_data_valid;
  logic [7:0] fb_dout;
  logic [7:0] fb_r_xpos;
  logic [7:0] fb_r_ypos;
  logic       fb_r_mode;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_first;

  modport master (
    input  fb_rst_complete, fb_r_data_valid, fb_dout, out_ready,
    output fb_re, fb_r_xpos, fb_r_ypos, fb_r_mode, out_data, out_valid, out_first
  );

  modport slave (
    output fb_rst_complete, fb_r_data_valid, fb_dout, out_ready,
    input  fb_re, fb_r_xpos, fb_r_ypos, fb_r_mode, out_data, out_valid, out_first
  );
endinterface

// File: rtl/oled_frame_streamer.sv
// Streams one framebuffer frame, page by page and column by column, as valid/ready bytes.
// Each byte costs at least 3 cycles plus framebuffer latency, and it stalls in OUT while out_ready is low.
// OLED_STREAM_BITREV_EN bit-reverses each byte so that bit0 is the top row.
module oled_frame_streamer #(
  parameter int H_PIXELS = 128,
  parameter int V_PIXELS = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  frame_done,
  oled_frame_streamer_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ, RELEASE, OUT, DONE} state_t;

  localparam logic [7:0] LAST_COL  = 8'(H_PIXELS - 1);
  localparam logic [7:0] LAST_PAGE = 8'(V_PIXELS / 8 - 1);

  state_t     state, state_nxt;
  logic [7:0] col;
  logic [7:0] page;
  logic [7:0] data_q;
  logic [7:0] out_byte;
  logic       accept;
  logic       in_frame;
  logic       last_col;
  logic       last_byte;

  assign accept    = (state == IDLE) && start && bus.fb_rst_complete;
  assign in_frame  = (state == REQ) || (state == RELEASE) || (state == OUT);
  assign last_col  = (col == LAST_COL);
  assign last_byte = last_col && (page == LAST_PAGE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = REQ;
      REQ:     if (bus.fb_r_data_valid) state_nxt = RELEASE;
      RELEASE: if (!bus.fb_r_data_valid) state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = last_byte ? DONE : REQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Losing the framebuffer mid-frame drops the frame silently.
    if (in_frame && !bus.fb_rst_complete) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col    <= '0;
      page   <= '0;
      data_q <= '0;
    end else if (accept) begin
      col  <= '0;
      page <= '0;
    end else begin
      if (state == REQ && bus.fb_r_data_valid) data_q <= bus.fb_dout;
      if (state == OUT && bus.out_ready) begin
        if (last_byte) begin
          col  <= '0;
          page <= '0;
        end else if (last_col) begin
          col  <= '0;
          page <= page + 8'd1;
        end else begin
          col <= col + 8'd1;
        end
      end
    end
  end

`ifdef OLED_STREAM_BITREV_EN
  always_comb begin
    out_byte = '0;
    for (int i = 0; i < 8; i++) out_byte[i] = data_q[7-i];
  end
`else
  assign out_byte = data_q;
`endif

  assign busy          = in_frame;
  assign frame_done    = (state == DONE);
  assign bus.fb_re     = (state == REQ);
  assign bus.fb_r_xpos = col;
  assign bus.fb_r_ypos = page << 3;
  assign bus.fb_r_mode = 1'b1;
  assign bus.out_valid = (state == OUT);
  assign bus.out_data  = out_byte;
  assign bus.out_first = (state == OUT) && (col == 8'd0) && (page == 8'd0);

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Directed bench for oled_frame_streamer: a pixel-level framebuffer model plus a per-cycle byte scoreboard.
module tb_oled_frame_streamer;
  localparam int H      = 128;
  localparam int V      = 64;
  localparam int NB     = H * V / 8;
  localparam int FB_LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, frame_done;

  oled_frame_streamer_if bus();

  oled_frame_streamer #(.H_PIXELS(H), .V_PIXELS(V)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int k = 0;
  int done_cnt = 0;
  int first_cnt = 0;
  logic [7:0] got [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Pixel image: the rows 0..7 pattern in the top-left 8x8, and a pseudo-random pattern elsewhere.
  function automatic logic pix(input int x, input int y);
    logic [7:0] r;
    if (x < 8 && y < 8) begin
      case (y % 4)
        0:       r = 8'hCC;
        1:       r = 8'hAA;
        2:       r = 8'hF0;
        default: r = 8'h0F;
      endcase
      return r[7-x];
    end
    return ((x * 5 + y * 3 + (x >> 3)) % 7) < 3;
  endfunction

  // Column-mode read: bit7 is the top row of the page.
  function automatic logic [7:0] col_byte(input int x, input int ypos);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = pix(x, ypos + i);
    return b;
  endfunction

  function automatic logic [7:0] exp_out(input int idx);
    logic [7:0] b, r;
    b = col_byte(idx % H, (idx / H) * 8);
`ifdef OLED_STREAM_BITREV_EN
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
`else
    r = b;
`endif
    return r;
  endfunction

  // Framebuffer responder: data valid FB_LAT cycles after the request, dropped once fb_re falls.
  initial begin
    int lat;
    lat = 0;
    bus.fb_r_data_valid = 1'b0;
    bus.fb_dout = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.fb_re === 1'b1) begin
        if (lat >= FB_LAT) begin
          bus.fb_r_data_valid = 1'b1;
          bus.fb_dout = col_byte(int'(bus.fb_r_xpos), int'(bus.fb_r_ypos));
        end else begin
          lat++;
        end
      end else begin
        lat = 0;
        bus.fb_r_data_valid = 1'b0;
      end
    end
  end

  // Scoreboard: k is the index, within the frame, of the next byte the stream must produce.
  always @(negedge clk) begin
    if (rst || !bus.fb_rst_complete) begin
      k = 0;
    end else begin
      chk("fb_r_mode", bus.fb_r_mode, 1'b1);
      if (bus.fb_re) begin
        chk("req_xpos", bus.fb_r_xpos, 8'(k % H));
        chk("req_ypos", bus.fb_r_ypos, 8'((k / H) * 8));
      end
      if (bus.out_valid) begin
        chk("out_data", bus.out_data, exp_out(k));
        chk("out_first", bus.out_first, (k == 0));
        chk("busy_in_out", busy, 1'b1);
        if (bus.out_ready) begin
          if (k < 4) got[k] = bus.out_data;
          if (bus.out_first) first_cnt++;
          k++;
        end
      end else begin
        chk("out_first_idle", bus.out_first, 1'b0);
      end
      if (frame_done) begin
        chk("frame_bytes", k, NB);
        done_cnt++;
        k = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_k(input int n);
    int budget;
    budget = 20000;
    while (k < n && budget > 0) begin tick(); budget--; end
    chk("reach_byte", (k >= n), 1'b1);
  endtask

  task automatic wait_done(input int n);
    int budget;
    budget = 20000;
    while (done_cnt < n && budget > 0) begin tick(); budget--; end
    chk("frame_done_count", done_cnt, n);
  endtask

  task automatic wait_sig(input string name, input bit want_re);
    int budget;
    budget = 200;
    while (budget > 0 && !(want_re ? bus.fb_re : bus.out_valid)) begin tick(); budget--; end
    chk(name, (want_re ? bus.fb_re : bus.out_valid), 1'b1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_fb_re", bus.fb_re, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_first", bus.out_first, 1'b0);
    chk("rst_out_data", bus.out_data, 8'h00);
    chk("rst_xpos", bus.fb_r_xpos, 8'h00);
    chk("rst_ypos", bus.fb_r_ypos, 8'h00);
    chk("rst_mode", bus.fb_r_mode, 1'b1);
  endtask

  initial begin
    logic [7:0] hold;
    bus.fb_rst_complete = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    check_reset_outputs();
    rst = 1'b0;
    tick();

    // Frame 1: first bytes, stall at byte 5, page wrap after byte 127, ignored mid-frame start.
    pulse_start();
    chk("busy_after_start", busy, 1'b1);
    wait_k(5);
    wait_sig("stall_reach_out", 1'b0);
    bus.out_ready = 1'b0;
    hold = bus.out_data;
    chk("stall_byte", hold, exp_out(5));
    repeat (20) begin
      tick();
      chk("stall_fb_re", bus.fb_re, 1'b0);
      chk("stall_valid", bus.out_valid, 1'b1);
      chk("stall_data", bus.out_data, hold);
    end
    chk("stall_index", k, 5);
    bus.out_ready = 1'b1;
    wait_k(128);
    wait_sig("wrap_req", 1'b1);
    chk("wrap_xpos", bus.fb_r_xpos, 8'd0);
    chk("wrap_ypos", bus.fb_r_ypos, 8'd8);
    pulse_start();
    wait_done(1);
`ifdef OLED_STREAM_BITREV_EN
    chk("byte0", got[0], 8'h77);
    chk("byte1", got[1], 8'h55);
    chk("byte2", got[2], 8'h66);
    chk("byte3", got[3], 8'h44);
`else
    chk("byte0", got[0], 8'hEE);
    chk("byte1", got[1], 8'hAA);
    chk("byte2", got[2], 8'h66);
    chk("byte3", got[3], 8'h22);
`endif
    chk("busy_after_f1", busy, 1'b0);
    chk("first_cnt_f1", first_cnt, 1);

    // Frame 2: clean full frame.
    pulse_start();
    wait_done(2);
    chk("busy_after_f2", busy, 1'b0);
    chk("first_cnt_f2", first_cnt, 2);

    // A start while the framebuffer is not ready is dropped, not queued.
    bus.fb_rst_complete = 1'b0;
    pulse_start();
    repeat (8) begin
      chk("norst_busy", busy, 1'b0);
      chk("norst_fb_re", bus.fb_re, 1'b0);
      tick();
    end
    bus.fb_rst_complete = 1'b1;
    repeat (3) tick();
    chk("no_queued_start", busy, 1'b0);
    pulse_start();
    chk("busy_after_ready", busy, 1'b1);

    // Reset at byte 300 abandons the frame.
    wait_k(300);
    rst = 1'b1;
    tick();
    check_reset_outputs();
    rst = 1'b0;
    repeat (4) tick();
    chk("rst_no_done", done_cnt, 2);
    pulse_start();
    wait_sig("restart_req", 1'b1);
    chk("restart_xpos", bus.fb_r_xpos, 8'd0);
    chk("restart_ypos", bus.fb_r_ypos, 8'd0);
    wait_done(3);
    chk("first_cnt_f4", first_cnt, 4);

    // fb_rst_complete falling mid-frame aborts without frame_done.
    pulse_start();
    wait_k(50);
    bus.fb_rst_complete = 1'b0;
    tick();
    chk("abort_fb_re", bus.fb_re, 1'b0);
    chk("abort_valid", bus.out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    repeat (3) tick();
    bus.fb_rst_complete = 1'b1;
    repeat (5) tick();
    chk("abort_no_done", done_cnt, 3);
    chk("abort_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/oled_frame_streamer.md
OLED_FRAME_STREAMER -- requirements
Module: oled_frame_streamer

Interface
REQ-001 SHALL have parameter H_PIXELS, default 128, meaning panel width in pixels (columns per page).
REQ-002 SHALL have parameter V_PIXELS, default 64, meaning panel height in pixels; page count = V_PIXELS/8.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to stream one full frame.
REQ-006 SHALL have port busy  output  1  high from frame acceptance until frame_done.
REQ-007 SHALL have port frame_done  output  1  one-cycle pulse after the last byte is accepted.
REQ-008 SHALL have port fb_rst_complete  input  1  framebuffer clear finished.
REQ-009 SHALL have port fb_re  output  1  framebuffer read request.
REQ-010 SHALL have port fb_r_data_valid  input  1  framebuffer read data valid.
REQ-011 SHALL have port fb_dout  input  8  framebuffer read data.
REQ-012 SHALL have ports fb_r_xpos and fb_r_ypos  output  8 each  read coordinates.
REQ-013 SHALL have port fb_r_mode  output  1  read mode, always 1 (column mode).
REQ-014 SHALL have port out_data  output  8  display byte toward the OLED serializer.
REQ-015 SHALL have port out_valid  output  1  out_data valid.
REQ-016 SHALL have port out_ready  input  1  downstream accepts the byte when high with out_valid.
REQ-017 SHALL have port out_first  output  1  high with the byte for page 0, column 0.

Function
REQ-018 SHALL stream bytes in page order 0..V_PIXELS/8-1, with columns 0..H_PIXELS-1 within each page: H_PIXELS*V_PIXELS/8 bytes per frame (1024 by default).
REQ-019 SHALL use the states IDLE, REQ, RELEASE, OUT and DONE.
REQ-020 IDLE SHALL accept start only while fb_rst_complete=1; start with fb_rst_complete=0 SHALL be ignored, not queued.
REQ-021 SHALL go from IDLE to REQ on accepted start, clearing the column and page counters and asserting busy the next cycle.
REQ-022 REQ SHALL drive fb_re=1, fb_r_xpos=column and fb_r_ypos=page*8; on fb_r_data_valid=1 it SHALL capture fb_dout and go to RELEASE.
REQ-023 RELEASE SHALL drive fb_re=0 and hold until fb_r_data_valid=0, then go to OUT.
REQ-024 OUT SHALL hold out_valid=1 with out_data stable until out_ready=1.
REQ-025 On out_ready=1 in OUT, the block SHALL advance the counters: column wraps from H_PIXELS-1 to 0 and increments page; after the final page and column it SHALL go to DONE, otherwise back to REQ.
REQ-026 DONE SHALL pulse frame_done for one cycle, deassert busy and return to IDLE.
REQ-027 start while busy SHALL be ignored.
REQ-028 fb_rst_complete falling mid-frame SHALL abort the frame to IDLE with fb_re=0, out_valid=0 and no frame_done.
REQ-029 out_first SHALL be 1 only when out_valid=1 at page 0, column 0.
REQ-030 Minimum cost per byte SHALL be 3 cycles plus framebuffer latency plus out_ready wait.

Reset
REQ-031 rst SHALL force IDLE, counters=0, and busy, frame_done, fb_re, out_valid, out_first=0, out_data=0, fb_r_xpos=0, fb_r_ypos=0 on the next clock edge.
REQ-032 rst asserted mid-frame SHALL abandon the frame with no frame_done; fb_r_mode SHALL stay 1 through reset.

Configuration
REQ-033 With OLED_STREAM_BITREV_EN defined, out_data SHALL be the bit-reverse of the captured byte (bit0 = top row, SSD1306 order).
REQ-034 Without OLED_STREAM_BITREV_EN, out_data SHALL equal the captured fb_dout unchanged (bit7 = top row).

Verification
REQ-035 Scenario 1: framebuffer rows 0..7 at x=0..7 hold CC,AA,F0,0F,CC,AA,F0,0F; start; out_ready=1 -> bytes 0,1,2,3 = 0xEE, 0xAA, 0x66, 0x22 without the macro, and 0x77, 0x55, 0x66, 0x44 with it.
REQ-036 Scenario 2: full frame with out_ready=1 -> exactly 1024 out_valid&out_ready transfers, out_first on the first only, one frame_done, busy low afterwards.
REQ-037 Scenario 3: out_ready held low 20 cycles at byte 5 -> out_data stable, fb_re=0 throughout the stall, no byte lost or duplicated.
REQ-038 Scenario 4: start with fb_rst_complete=0 -> busy stays 0, fb_re never asserts; start after fb_rst_complete=1 -> frame runs.
REQ-039 Scenario 5: rst at byte 300 -> next cycle all outputs at reset values, no frame_done; a new start restreams from page 0, column 0.
REQ-040 Scenario 6: byte 127 accepted -> next request uses fb_r_xpos=0, fb_r_ypos=8; start pulsed mid-frame -> ignored.
